// File: rtl/sd_card_writer.sv
// Streams BLOCK_COUNT blocks from a 1-bit frame RAM to an initialised SD card as CMD24 writes.
// Each SPI byte takes 16 clk_spi cycles; each data byte is preceded by an 11-cycle RAM fetch.
module sd_card_writer #(
   parameter int BLOCK_COUNT  = 192,
   parameter int BUSY_TIMEOUT = 65535
) (
   input  logic        clk_spi,
   input  logic        reset_btn,
   input  logic        start,
   input  logic [31:0] base_sector,
   output logic        sd_cs,
   output logic        sd_sclk,
   output logic        sd_mosi,
   input  logic        sd_miso,
   output logic [23:0] address,
   output logic        rden,
   input  logic        read_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  err_code
);

   typedef enum logic [3:0] {
      IDLE, CMD, R1WAIT, GAP, TOKEN, FETCH, DATA, CRC, DRESP, BUSYPOLL, NEXT, FAIL
   } state_t;

   localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
   localparam logic [12:0] BLK_END   = 13'(BLOCK_COUNT);

   state_t      state;
   logic [3:0]  phase;
   logic [15:0] cnt;
   logic [3:0]  fc;
   logic [11:0] blk;
   logic [31:0] base_r;
   logic [31:0] arg;
   logic [7:0]  data_byte;
   logic [6:0]  rx_sr;
   logic [2:0]  fail_code;
   logic [7:0]  tx_byte;
   logic [7:0]  rx_byte;
   logic        byte_end;

   assign arg      = base_r + {20'd0, blk};
   assign rx_byte  = {rx_sr, sd_miso};
   assign byte_end = (phase == 4'd15);

   always_comb begin
      tx_byte = 8'hFF;
      case (state)
         CMD: begin
            case (cnt[2:0])
               3'd0:    tx_byte = 8'h58;
               3'd1:    tx_byte = arg[31:24];
               3'd2:    tx_byte = arg[23:16];
               3'd3:    tx_byte = arg[15:8];
               3'd4:    tx_byte = arg[7:0];
               default: tx_byte = 8'hFF;
            endcase
         end
         TOKEN:   tx_byte = 8'hFE;
         DATA:    tx_byte = data_byte;
         default: tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk_spi or posedge reset_btn) begin
      if (reset_btn) begin
         state     <= IDLE;
         sd_cs     <= 1'b1;
         sd_sclk   <= 1'b0;
         sd_mosi   <= 1'b1;
         address   <= 24'd0;
         rden      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_code  <= 3'd0;
         phase     <= 4'd0;
         cnt       <= 16'd0;
         fc        <= 4'd0;
         blk       <= 12'd0;
         base_r    <= 32'd0;
         data_byte <= 8'd0;
         rx_sr     <= 7'd0;
         fail_code <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sd_cs   <= 1'b1;
               sd_sclk <= 1'b0;
               sd_mosi <= 1'b1;
               address <= 24'd0;
               rden    <= 1'b0;
               phase   <= 4'd0;
               cnt     <= 16'd0;
               if (start) begin
                  busy     <= 1'b1;
                  error    <= 1'b0;
                  err_code <= 3'd0;
                  blk      <= 12'd0;
                  base_r   <= base_sector;
                  state    <= CMD;
               end
            end

            // Eight reads in flight; data for the read issued at fc=n lands at fc=n+3.
            FETCH: begin
               sd_cs   <= 1'b0;
               sd_sclk <= 1'b0;
               if (fc < 4'd8) begin
                  address <= {blk, cnt[8:0], fc[2:0]};
                  rden    <= 1'b1;
               end else begin
                  rden <= 1'b0;
               end
               if (fc >= 4'd3)
                  data_byte <= {data_byte[6:0], read_data};
               if (fc == 4'd10) begin
                  phase <= 4'd0;
                  state <= DATA;
               end else begin
                  fc <= fc + 4'd1;
               end
            end

            FAIL: begin
               sd_cs    <= 1'b1;
               sd_sclk  <= 1'b0;
               sd_mosi  <= 1'b1;
               rden     <= 1'b0;
               error    <= 1'b1;
               err_code <= fail_code;
               busy     <= 1'b0;
               state    <= IDLE;
            end

            // Byte states: even phases drive mosi with sclk low, odd phases raise sclk and sample miso.
            default: begin
               sd_cs <= (state == NEXT);
               rden  <= 1'b0;
               if (!phase[0]) begin
                  sd_sclk <= 1'b0;
                  sd_mosi <= tx_byte[3'd7 - phase[3:1]];
               end else begin
                  sd_sclk <= 1'b1;
                  rx_sr   <= {rx_sr[5:0], sd_miso};
               end
               phase <= phase + 4'd1;
               if (byte_end) begin
                  case (state)
                     CMD: begin
                        if (cnt == 16'd5) begin
                           cnt   <= 16'd0;
                           state <= R1WAIT;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end
                     R1WAIT: begin
                        if (!rx_byte[7]) begin
                           if (rx_byte == 8'h00) begin
                              state <= GAP;
                           end else begin
                              fail_code <= 3'd2;
                              state     <= FAIL;
                           end
                        end else if (cnt == 16'd7) begin
                           fail_code <= 3'd1;
                           state     <= FAIL;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end
                     GAP:   state <= TOKEN;
                     TOKEN: begin
                        cnt   <= 16'd0;
                        fc    <= 4'd0;
                        state <= FETCH;
                     end
                     DATA: begin
                        if (cnt == 16'd511) begin
                           cnt   <= 16'd0;
                           state <= CRC;
                        end else begin
                           cnt   <= cnt + 16'd1;
                           fc    <= 4'd0;
                           state <= FETCH;
                        end
                     end
                     CRC: begin
                        if (cnt == 16'd1) begin
                           cnt   <= 16'd0;
                           state <= DRESP;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end
                     DRESP: begin
                        if (!rx_byte[4]) begin
                           if (rx_byte[4:0] == 5'h05) begin
                              cnt   <= 16'd0;
                              state <= BUSYPOLL;
                           end else begin
                              fail_code <= 3'd3;
                              state     <= FAIL;
                           end
                        end else if (cnt == 16'd7) begin
                           fail_code <= 3'd3;
                           state     <= FAIL;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end
                     BUSYPOLL: begin
                        if (rx_byte == 8'hFF) begin
                           state <= NEXT;
                        end else if (cnt == BUSY_LAST) begin
                           fail_code <= 3'd4;
                           state     <= FAIL;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end
                     NEXT: begin
                        if ({1'b0, blk} + 13'd1 == BLK_END) begin
                           done  <= 1'b1;
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           blk   <= blk + 12'd1;
                           cnt   <= 16'd0;
                           state <= CMD;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: doc/sd_card_writer.md
SD_CARD_WRITER -- requirements
Module: sd_card_writer

Interface
REQ-001 Parameter BLOCK_COUNT, default 192, number of 512-byte blocks written per run (192 x 4096 bits = 786432-bit RAM).
REQ-002 Parameter BUSY_TIMEOUT, default 65535, maximum busy-poll bytes after a data response.
REQ-003 clk_spi  in  1  5 MHz system/SPI clock; all logic on its rising edge.
REQ-004 reset_btn  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a run; ignored while busy=1.
REQ-006 base_sector  in  32  first card block address (SDHC block addressing); sampled on accepted start.
REQ-007 sd_cs  out  1  card chip select, active low.
REQ-008 sd_sclk  out  1  SPI clock, mode 0, clk_spi/2.
REQ-009 sd_mosi  out  1  SPI data to card.
REQ-010 sd_miso  in  1  SPI data from card.
REQ-011 address  out  24  bit address into the 1-bit frame RAM.
REQ-012 rden  out  1  RAM read enable.
REQ-013 read_data  in  1  RAM output, valid on the 2nd clk_spi edge after address/rden are presented.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse when all blocks are written successfully.
REQ-016 error  out  1  run aborted; held until next accepted start or reset.
REQ-017 err_code  out  3  0 none, 1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout.

Function
REQ-018 Card is already initialised by the reader; this block issues only CMD24 single-block writes.
REQ-019 SPI byte = 8 bits MSB first; sd_mosi changes while sd_sclk is low; sd_miso is sampled on the sclk rising transition; 16 clk_spi cycles per byte.
REQ-020 States: IDLE, CMD, R1WAIT, GAP, TOKEN, FETCH, DATA, CRC, DRESP, BUSYPOLL, NEXT, FAIL.
REQ-021 IDLE: sd_cs=1, sd_mosi=1, sd_sclk=0; accepted start sets busy=1, clears error/err_code, block index=0 -> CMD.
REQ-022 CMD: sd_cs=0; send 0x58, argument (base_sector+block index, 32-bit wrap) big-endian, 0xFF.
REQ-023 R1WAIT: send 0xFF; first received byte with bit7=0 is R1; 0x00 -> GAP; nonzero -> FAIL code 2; none within 8 bytes -> FAIL code 1.
REQ-024 GAP: send one 0xFF byte; TOKEN: send 0xFE.
REQ-025 FETCH: read 8 RAM bits into a byte register; RAM bit address = block*4096 + byte*8 + k, k=0 becomes MSB on the wire; rden=1 only in FETCH.
REQ-026 DATA: send fetched byte; FETCH/DATA alternate for 512 bytes; no sd_sclk activity during FETCH (sclk held low).
REQ-027 CRC: send 0xFF, 0xFF.
REQ-028 DRESP: send 0xFF; first received byte with bit0... masked (byte & 0x1F)==0x05 -> BUSYPOLL; any other value with bit4=0 -> FAIL code 3; allow up to 8 bytes, else FAIL code 3.
REQ-029 BUSYPOLL: send 0xFF until a received byte equals 0xFF -> NEXT; BUSY_TIMEOUT bytes without 0xFF -> FAIL code 4.
REQ-030 NEXT: sd_cs=1 for one 0xFF byte (8 sclks); block index+1; equals BLOCK_COUNT -> done pulse, busy=0, IDLE; else CMD.
REQ-031 FAIL: sd_cs=1, error=1, err_code latched, busy=0 -> IDLE in the next cycle.
REQ-032 start asserted in the same cycle the run ends is ignored; a new start is required.
REQ-033 address holds its last value between fetches; set to 0 in IDLE.

Reset
REQ-034 reset_btn=1 at any time, including mid-byte: sd_cs=1, sd_sclk=0, sd_mosi=1, address=0, rden=0, busy=0, done=0, error=0, err_code=0, state IDLE, block index=0.
REQ-035 No partial byte resumes after reset; the next accepted start begins a fresh CMD24.

Verification
REQ-036 Reset release -> all REQ-034 values; 100 idle cycles with start=0 -> no sd_sclk edges.
REQ-037 BLOCK_COUNT=2, base_sector=0x10, card model R1=0x00, response 0xE5, 3 busy bytes 0x00 -> bytes 58 00 00 00 10 FF, FE, 512 bytes equal to RAM bits 0..4095, FF FF; second command argument 0x11; single done pulse.
REQ-038 sd_miso held 1 after CMD -> after 8 poll bytes error=1, err_code=1, sd_cs=1, busy=0.
REQ-039 R1=0x04 -> err_code=2; data response 0x0B -> err_code=3; busy held 0x00 with BUSY_TIMEOUT=16 -> err_code=4.
REQ-040 reset_btn pulse during DATA byte 100 -> REQ-034 values at once; then start -> stream begins again with 0x58.
REQ-041 RAM pattern 1,0,0,0,0,0,0,0 per byte -> every data byte on wire 0x80; start pulse during busy -> no effect on stream or block count.
